seq_divider: RTL and testbench

//   Responder side of the control unit's DivInit/DivStop/DivZero handshake: multicycle restoring divider.

---
 rtl/seq_div_pkg.sv | 26 ++
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 125 ++++++++++++
 tb/tb_seq_divider.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
//   state_e        : divider FSM states
//   DivWidth       : default operand/result width
//   count_width()  : iteration counter width for a given operand width, $clog2(width+1)
//   DivCntWidth    : counter width for the default operand width
//   MinInt         : most negative two's-complement value at the default width
package seq_div_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StIter,
    StFix
  } state_e;

  localparam int unsigned DivWidth = 32;

  function automatic int unsigned count_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DivCntWidth = count_width(DivWidth);

  localparam logic [DivWidth-1:0] MinInt = {1'b1, {(DivWidth - 1){1'b0}}};

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   rem       in  : partial remainder
//   quo       in  : dividend/quotient shift register; its MSB feeds the remainder
//   divisor   in  : divisor magnitude
//   rem_next  out : remainder after the trial subtraction
//   quo_next  out : quotient shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           fits;

  assign shifted = {rem, quo[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor};
  // shifted < 2*divisor, so a clear top bit of the difference means shifted >= divisor.
  assign fits    = ~diff[WIDTH];

  assign rem_next = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/seq_divider.sv
// Multicycle restoring divider answering the DivInit/DivStop/DivZero handshake.
// Produces the MIPS div quotient (lo) and remainder (hi); quotient truncates toward
// zero and the remainder takes the dividend's sign.
//   clk, reset          : clock, synchronous active-high reset
//   start               : DivInit, only sampled while idle
//   is_unsigned         : (SEQ_DIV_UNSIGNED_EN only) divu when 1, sampled with start
//   dividend, divisor   : operands, captured when start is accepted
//   busy                : operation in progress
//   done                : DivStop, one-cycle pulse
//   div_zero            : DivZero, one-cycle pulse alongside done
//   hi, lo              : remainder, quotient; held until the next successful completion
// Build option: define SEQ_DIV_UNSIGNED_EN to add the is_unsigned port.
module seq_divider
  import seq_div_pkg::*;
#(
  parameter int unsigned WIDTH = DivWidth
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
`ifdef SEQ_DIV_UNSIGNED_EN
  input  logic             is_unsigned,
`endif
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned     CntW     = count_width(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  state_e          state_q;
  logic [WIDTH-1:0] quo_q;   // raw dividend, then magnitude, then quotient
  logic [WIDTH-1:0] dvs_q;   // raw divisor, then magnitude
  logic [WIDTH-1:0] rem_q;
  logic [CntW-1:0]  cnt_q;
  logic             dvd_neg_q;
  logic             dvs_neg_q;
  logic [WIDTH-1:0] step_rem;
  logic [WIDTH-1:0] step_quo;
  logic             signed_op;

`ifdef SEQ_DIV_UNSIGNED_EN
  assign signed_op = ~is_unsigned;
`else
  assign signed_op = 1'b1;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem     (rem_q),
    .quo     (quo_q),
    .divisor (dvs_q),
    .rem_next(step_rem),
    .quo_next(step_quo)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      quo_q     <= '0;
      dvs_q     <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            quo_q     <= dividend;
            dvs_q     <= divisor;
            // Unsigned ops never look negative, so the later fix-ups fall away.
            dvd_neg_q <= signed_op & dividend[WIDTH-1];
            dvs_neg_q <= signed_op & divisor[WIDTH-1];
            busy      <= 1'b1;
            state_q   <= StLoad;
          end
        end
        StLoad: begin
          if (dvs_q == '0) begin
            done     <= 1'b1;
            div_zero <= 1'b1;
            busy     <= 1'b0;
            state_q  <= StIdle;
          end else begin
            // Negating MIN_INT gives back its own bit pattern, the correct unsigned magnitude.
            if (dvd_neg_q) quo_q <= -quo_q;
            if (dvs_neg_q) dvs_q <= -dvs_q;
            rem_q   <= '0;
            cnt_q   <= '0;
            state_q <= StIter;
          end
        end
        StIter: begin
          rem_q <= step_rem;
          quo_q <= step_quo;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastStep) state_q <= StFix;
        end
        StFix: begin
          lo       <= (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
          hi       <= dvd_neg_q ? -rem_q : rem_q;
          done     <= 1'b1;
          busy     <= 1'b0;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;
  import seq_div_pkg::*;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int unsigned due;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;
`ifdef SEQ_DIV_UNSIGNED_EN
  logic        is_unsigned;
`endif

  exp_t        sb[$];
  int unsigned edge_cnt;
  int          checks;
  int          errors;
  logic        prev_done;

  seq_divider #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
`ifdef SEQ_DIV_UNSIGNED_EN
    .is_unsigned(is_unsigned),
`endif
    .dividend(dividend),
    .divisor (divisor),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected result.
  initial prev_done = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", {31'b0, done}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("lo", lo, e.lo);
          check("hi", hi, e.hi);
          check("div_zero", {31'b0, div_zero}, {31'b0, e.dz});
          check("latency", edge_cnt, e.due);
        end
      end else if (div_zero) begin
        check("div_zero_without_done", {31'b0, div_zero}, 32'd0);
      end
      if (done && prev_done) check("done_pulse_width", {31'b0, prev_done}, 32'd0);
    end
    prev_done = done;
  end

  // Called on a negedge with the DUT idle; the next posedge samples start.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ehi,
                       input logic [31:0] elo, input logic edz);
    exp_t e;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    e.hi  = ehi;
    e.lo  = elo;
    e.dz  = edz;
    e.due = edge_cnt + 1 + (edz ? 1 : 34);
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d results still pending at edge %0d", sb.size(), edge_cnt);
      sb.delete();
    end
  endtask

  task automatic wait_edge(input int unsigned target);
    int n = 0;
    while (edge_cnt < target && n < 200) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    int unsigned n0;
    exp_t        e;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
`ifdef SEQ_DIV_UNSIGNED_EN
    is_unsigned = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_div_zero", {31'b0, div_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Signed basics: truncation toward zero, remainder follows the dividend.
    issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);                         drain();
    issue(32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFF2, 1'b0);    drain();
    issue(32'd100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFF2, 1'b0);          drain();
    issue(32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd14, 1'b0);   drain();
    // Divide by zero keeps the previous result.
    issue(32'd5, 32'd0, 32'hFFFF_FFFE, 32'd14, 1'b1);                   drain();
    issue(MinInt, 32'hFFFF_FFFF, 32'd0, MinInt, 1'b0);                  drain();
    issue(32'd0, 32'd5, 32'd0, 32'd0, 1'b0);                            drain();
    issue(32'd7, 32'd7, 32'd0, 32'd1, 1'b0);                            drain();
    issue(32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'd0, 1'b0);            drain();
    issue(32'd12345678, 32'd1000, 32'd678, 32'd12345, 1'b0);            drain();
`ifdef SEQ_DIV_UNSIGNED_EN
    is_unsigned = 1'b1;
    issue(32'hFFFF_FFFF, 32'd2, 32'd1, 32'h7FFF_FFFF, 1'b0);            drain();
    is_unsigned = 1'b0;
`endif

    // start while busy is dropped; a divisor of zero would finish early if it were taken.
    n0 = edge_cnt + 1;
    issue(32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    check("busy_during_op", {31'b0, busy}, 32'd1);
    wait_edge(n0 + 9);
    dividend = 32'd9;
    divisor  = 32'd0;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    drain();
    check("busy_after_done", {31'b0, busy}, 32'd0);
    repeat (40) @(negedge clk);

    // start held across done: the second op is accepted on the first idle edge.
    dividend = 32'd50;
    divisor  = 32'd6;
    start    = 1'b1;
    n0       = edge_cnt + 1;
    e.hi = 32'd2; e.lo = 32'd8; e.dz = 1'b0; e.due = n0 + 34;
    sb.push_back(e);
    wait_edge(n0 + 34);
    dividend = 32'd77;
    divisor  = 32'd10;
    e.hi = 32'd7; e.lo = 32'd7; e.dz = 1'b0; e.due = n0 + 35 + 34;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    drain();

    // Reset mid-operation aborts silently and clears the outputs.
    n0 = edge_cnt + 1;
    issue(32'd500, 32'd9, 32'd5, 32'd55, 1'b0);
    wait_edge(n0 + 19);
    reset = 1'b1;
    @(negedge clk);
    sb.delete();
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_done", {31'b0, done}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd100, 32'd7, 32'd2, 32'd14, 1'b0);                         drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
